// File: rtl/fetch_seq_ctrl.sv
// Fetch-side PC sequencer: issues imem requests over a req/ack handshake,
// applies ID-stage redirects with one delay slot, and feeds a one-entry IF buffer.
module fetch_seq_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [1:0]  npc_op,
  input  logic [31:0] id_pc,
  input  logic [25:0] imm26,
  input  logic [31:0] ra,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc4
);

  typedef enum logic {BOOT, RUN} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic        pend_valid_q, pend_valid_d;
  logic [31:0] pend_pc_q, pend_pc_d;

  logic        fetch_done;
  logic        redir_acc;
  logic [31:0] target;

  assign imem_req   = reset & (state_q == RUN) & (!if_valid_q | !stall);
  assign imem_addr  = pc_q;
  assign fetch_done = imem_req & imem_ack;
  assign redir_acc  = redirect_valid & !stall & (npc_op != 2'b00);

  assign if_valid = if_valid_q;
  assign if_instr = if_instr_q;
  assign if_pc    = if_pc_q;
  assign if_pc4   = if_pc_q + 32'd4;

  always_comb begin
    target = ra;
    unique case (npc_op)
      2'b01:   target = id_pc + 32'd4 + {{14{imm26[15]}}, imm26[15:0], 2'b00};
      2'b10:   target = {id_pc[31:28], imm26, 2'b00};
      default: target = ra;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    if_valid_d   = if_valid_q;
    if_instr_d   = if_instr_q;
    if_pc_d      = if_pc_q;
    pend_valid_d = pend_valid_q;
    pend_pc_d    = pend_pc_q;

    if (state_q == BOOT) state_d = RUN;

    // A completing fetch always consumes any pending target; a same-cycle
    // redirect supersedes it, matching the overwrite rule for pend_pc.
    if (fetch_done) begin
      if_valid_d   = 1'b1;
      if_instr_d   = imem_rdata;
      if_pc_d      = pc_q;
      pend_valid_d = 1'b0;
      if (redir_acc)         pc_d = target;
      else if (pend_valid_q) pc_d = pend_pc_q;
      else                   pc_d = pc_q + 32'd4;
    end else begin
      if (if_valid_q && !stall) if_valid_d = 1'b0;
      if (redir_acc) begin
        pend_valid_d = 1'b1;
        pend_pc_d    = target;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= BOOT;
      pc_q         <= RESET_PC;
      if_valid_q   <= 1'b0;
      if_instr_q   <= '0;
      if_pc_q      <= '0;
      pend_valid_q <= 1'b0;
      pend_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      if_valid_q   <= if_valid_d;
      if_instr_q   <= if_instr_d;
      if_pc_q      <= if_pc_d;
      pend_valid_q <= pend_valid_d;
      pend_pc_q    <= pend_pc_d;
    end
  end

endmodule

// File: tb/tb_fetch_seq_ctrl.sv
// Directed bench for fetch_seq_ctrl: boot, latency, stall, redirects and reset mid-fetch.
module tb_fetch_seq_ctrl;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [1:0]  npc_op;
  logic [31:0] id_pc;
  logic [25:0] imm26;
  logic [31:0] ra;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc4;

  int n_cmp;
  int n_fail;

  fetch_seq_ctrl #(.RESET_PC(32'h0000_3000)) dut (
    .clk(clk), .reset(reset), .stall(stall), .redirect_valid(redirect_valid),
    .npc_op(npc_op), .id_pc(id_pc), .imm26(imm26), .ra(ra),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .if_valid(if_valid), .if_instr(if_instr),
    .if_pc(if_pc), .if_pc4(if_pc4)
  );

  // Memory word is a fixed function of its address so if_instr is predictable.
  assign imem_rdata = imem_addr ^ 32'hDEAD_0000;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic boot();
    reset = 1'b0; stall = 1'b0; redirect_valid = 1'b0; npc_op = 2'b00;
    step();
    reset = 1'b1;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b0; stall = 1'b0; redirect_valid = 1'b0; npc_op = 2'b00;
    id_pc = '0; imm26 = '0; ra = '0; imem_ack = 1'b1;
    step(); step(); #1;
    n_cmp++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b want 0", imem_req); end
    n_cmp++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", if_valid); end
    n_cmp++; if (if_pc !== 32'h0) begin n_fail++; $display("FAIL rst_if_pc: got %h want 0", if_pc); end
    n_cmp++; if (if_instr !== 32'h0) begin n_fail++; $display("FAIL rst_instr: got %h want 0", if_instr); end
    n_cmp++; if (imem_addr !== 32'h3000) begin n_fail++; $display("FAIL rst_addr: got %h want 3000", imem_addr); end
    reset = 1'b1; #1;
    n_cmp++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL boot_req: got %b want 0", imem_req); end
    step();
    n_cmp++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL run_req: got %b want 1", imem_req); end
  endtask

  task automatic test_free_run();
    imem_ack = 1'b1;
    boot(); #1;
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h3000) begin n_fail++; $display("FAIL fr_first_req: got %b/%h want 1/3000", imem_req, imem_addr); end
    n_cmp++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL fr_not_yet: got %b want 0", if_valid); end
    step();
    n_cmp++; if (if_valid !== 1'b1 || if_pc !== 32'h3000) begin n_fail++; $display("FAIL fr_first: got %b/%h want 1/3000", if_valid, if_pc); end
    n_cmp++; if (if_pc4 !== 32'h3004) begin n_fail++; $display("FAIL fr_pc4: got %h want 3004", if_pc4); end
    n_cmp++; if (if_instr !== 32'hDEAD_3000) begin n_fail++; $display("FAIL fr_instr: got %h want dead3000", if_instr); end
    for (int unsigned i = 1; i <= 4; i++) begin
      step();
      n_cmp++; if (if_valid !== 1'b1 || if_pc !== 32'h3000 + 32'(4 * i)) begin n_fail++; $display("FAIL fr_seq%0d: got %b/%h want 1/%h", i, if_valid, if_pc, 32'h3000 + 32'(4 * i)); end
    end
  endtask

  task automatic test_latency();
    imem_ack = 1'b0;
    boot();
    for (int unsigned i = 0; i < 2; i++) begin
      #1;
      n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h3000 || if_valid !== 1'b0) begin n_fail++; $display("FAIL lat_wait%0d: got %b/%h/%b want 1/3000/0", i, imem_req, imem_addr, if_valid); end
      step();
    end
    imem_ack = 1'b1; #1;
    n_cmp++; if (imem_addr !== 32'h3000) begin n_fail++; $display("FAIL lat_hold: got %h want 3000", imem_addr); end
    step();
    imem_ack = 1'b0; #1;
    n_cmp++; if (if_valid !== 1'b1 || if_pc !== 32'h3000 || imem_addr !== 32'h3004) begin n_fail++; $display("FAIL lat_done: got %b/%h/%h want 1/3000/3004", if_valid, if_pc, imem_addr); end
    step();
    n_cmp++; if (if_valid !== 1'b0 || imem_addr !== 32'h3004) begin n_fail++; $display("FAIL lat_pulse: got %b/%h want 0/3004", if_valid, imem_addr); end
    step();
    imem_ack = 1'b1;
    step();
    imem_ack = 1'b0; #1;
    n_cmp++; if (if_valid !== 1'b1 || if_pc !== 32'h3004) begin n_fail++; $display("FAIL lat_second: got %b/%h want 1/3004", if_valid, if_pc); end
  endtask

  task automatic test_stall();
    imem_ack = 1'b1;
    boot();
    step();
    stall = 1'b1;
    redirect_valid = 1'b1; npc_op = 2'b10; id_pc = 32'h3000; imm26 = 26'h0000C10;
    for (int unsigned i = 0; i < 4; i++) begin
      #1;
      n_cmp++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL st_req%0d: got %b want 0", i, imem_req); end
      n_cmp++; if (if_valid !== 1'b1 || if_pc !== 32'h3000 || if_instr !== 32'hDEAD_3000) begin n_fail++; $display("FAIL st_hold%0d: got %b/%h/%h want 1/3000/dead3000", i, if_valid, if_pc, if_instr); end
      step();
    end
    redirect_valid = 1'b0; npc_op = 2'b00; stall = 1'b0; #1;
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h3004) begin n_fail++; $display("FAIL st_release: got %b/%h want 1/3004", imem_req, imem_addr); end
    step();
    n_cmp++; if (if_valid !== 1'b1 || if_pc !== 32'h3004) begin n_fail++; $display("FAIL st_next: got %b/%h want 1/3004", if_valid, if_pc); end
  endtask

  task automatic test_branch();
    imem_ack = 1'b1;
    boot();
    repeat (5) step();
    redirect_valid = 1'b1; npc_op = 2'b01; id_pc = 32'h3010; imm26 = 26'h000FFFC; #1;
    n_cmp++; if (imem_addr !== 32'h3014) begin n_fail++; $display("FAIL br_slot_addr: got %h want 3014", imem_addr); end
    step();
    redirect_valid = 1'b0; npc_op = 2'b00; #1;
    n_cmp++; if (if_pc !== 32'h3014 || imem_addr !== 32'h3004) begin n_fail++; $display("FAIL br_target: got %h/%h want 3014/3004", if_pc, imem_addr); end
    step();
    n_cmp++; if (if_pc !== 32'h3004 || if_pc4 !== 32'h3008 || if_valid !== 1'b1) begin n_fail++; $display("FAIL br_fetch: got %h/%h/%b want 3004/3008/1", if_pc, if_pc4, if_valid); end
  endtask

  task automatic test_jr_pend();
    imem_ack = 1'b1;
    boot();
    repeat (5) step();
    imem_ack = 1'b0;
    step();
    redirect_valid = 1'b1; npc_op = 2'b11; ra = 32'h0000_4000;
    step();
    redirect_valid = 1'b0; npc_op = 2'b00; ra = 32'h0; #1;
    n_cmp++; if (imem_addr !== 32'h3014 || if_valid !== 1'b0) begin n_fail++; $display("FAIL jr_wait: got %h/%b want 3014/0", imem_addr, if_valid); end
    imem_ack = 1'b1;
    step();
    n_cmp++; if (if_pc !== 32'h3014 || imem_addr !== 32'h4000) begin n_fail++; $display("FAIL jr_pend_use: got %h/%h want 3014/4000", if_pc, imem_addr); end
    step();
    n_cmp++; if (if_pc !== 32'h4000 || imem_addr !== 32'h4004) begin n_fail++; $display("FAIL jr_pend_clr: got %h/%h want 4000/4004", if_pc, imem_addr); end
  endtask

  task automatic test_jump();
    imem_ack = 1'b1;
    boot();
    redirect_valid = 1'b1; npc_op = 2'b10; id_pc = 32'h3000; imm26 = 26'h0000C10;
    step();
    redirect_valid = 1'b0; #1;
    n_cmp++; if (if_pc !== 32'h3000 || imem_addr !== 32'h3040) begin n_fail++; $display("FAIL j_target: got %h/%h want 3000/3040", if_pc, imem_addr); end
    step();
    n_cmp++; if (if_pc !== 32'h3040) begin n_fail++; $display("FAIL j_fetch: got %h want 3040", if_pc); end
    redirect_valid = 1'b1; npc_op = 2'b00; ra = 32'h0000_8000;
    step();
    redirect_valid = 1'b0; #1;
    n_cmp++; if (if_pc !== 32'h3044 || imem_addr !== 32'h3048) begin n_fail++; $display("FAIL op00_ignored: got %h/%h want 3044/3048", if_pc, imem_addr); end
  endtask

  task automatic test_reset_midfetch();
    imem_ack = 1'b1;
    boot();
    step();
    imem_ack = 1'b0;
    step();
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h3004) begin n_fail++; $display("FAIL mf_inflight: got %b/%h want 1/3004", imem_req, imem_addr); end
    reset = 1'b0; #1;
    n_cmp++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL mf_req_in_reset: got %b want 0", imem_req); end
    imem_ack = 1'b1;
    step();
    n_cmp++; if (if_valid !== 1'b0 || imem_addr !== 32'h3000 || imem_req !== 1'b0) begin n_fail++; $display("FAIL mf_after_rst: got %b/%h/%b want 0/3000/0", if_valid, imem_addr, imem_req); end
    reset = 1'b1;
    step();
    imem_ack = 1'b0; #1;
    n_cmp++; if (if_valid !== 1'b0 || imem_addr !== 32'h3000) begin n_fail++; $display("FAIL mf_late_ack: got %b/%h want 0/3000", if_valid, imem_addr); end
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    test_reset();
    test_free_run();
    test_latency();
    test_stall();
    test_branch();
    test_jr_pend();
    test_jump();
    test_reset_midfetch();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
